single_clk_rx: RTL and testbench
================================

# single_clk_rx

Receiver/checker for the single-shot low-high-low frame produced by our `single_clk` generator. It watches the frame line and measures the three segment lengths in `clk_in` cycles. Each length is checked against the nominal value ± tolerance, and the block reports pass/fail with one done pulse. It sits on the far side of the frame line, with a board pull-up, so an undriven (idle) line reads 1.

## Interface
- `T_LOW1`, 200: nominal first-low length, cycles
- `T_HIGH`, 100: nominal high length, cycles
- `T_LOW2`, 200: nominal second-low length, cycles
- `TOL`, 4: allowed ± deviation per segment
- `CW`, 16: counter / length width
- `clk_in`  in  1  10 MHz clock; one clock domain
- `rst`  in  1  asynchronous, active-high reset
- `sig_in`  in  1  frame line, asynchronous to `clk_in`, idle high
- `busy`  out  1  high while a frame is being measured
- `done`  out  1  one-cycle pulse at end of frame or on error
- `ok`  out  1  valid with `done`: all three segments in tolerance
- `err`  out  2  valid with `done`: 0 none, 1 segment too short, 2 segment too long
- `len_low1`, `len_high`, `len_low2`  out  CW each  measured lengths; hold until the next frame starts

## Operation
- `sig_in` passes through a 2-flop synchronizer, giving `sig_s`. All decisions use `sig_s`.
- States: IDLE, LOW1, HIGH, LOW2, DRAIN.
- IDLE
  - On `sig_s`=0, go to LOW1.
  - Set `cnt`=1 and clear all `len_*`.
  - `busy`=1 from this point.
- LOW1 / HIGH / LOW2, while the level is unchanged:
  - `cnt`++ each cycle, saturating at 2^CW−1.
- On a level change:
  - Store `cnt` in that segment's `len_*` and reload `cnt`=1.
  - LOW1→HIGH, HIGH→LOW2, LOW2→IDLE.
- Short check, at each segment end:
  - If `cnt` < T−TOL, latch a short flag (err=1).
  - Measurement continues so all three lengths are reported.
- Long check, in any segment:
  - If `cnt` reaches T+TOL+1, store `cnt` in that segment's `len_*`.
  - Pulse `done` with `ok`=0, `err`=2, and go to DRAIN.
  - Remaining `len_*` stay 0.
- LOW2→IDLE exit:
  - Pulse `done`.
  - `ok`=1 and `err`=0 if no flag was set; otherwise `ok`=0, `err`=1.
- DRAIN: wait for `sig_s`=1, then go to IDLE. No further `done` for this frame.
- Arithmetic:
  - Window limits are computed at elaboration, CW bits.
  - Comparisons are unsigned.
  - A saturated `cnt` always counts as too long.

## Timing
- Reset values: state IDLE; `cnt`=0; `busy`=0, `done`=0, `ok`=0, `err`=0; all `len_*`=0; synchronizer flops=1.
- Reset mid-frame aborts immediately, with no `done`. After reset, the next falling edge of `sig_s` starts a new frame. If the line is low at reset release, IDLE waits for it to go high first (entered via DRAIN).
- Input latency:
  - `sig_s` lags `sig_in` by 2 cycles.
  - `done` rises on the 3rd `clk_in` edge after `sig_in` is first sampled high at frame end.
- Lengths are exact when `sig_in` transitions are synchronous to `clk_in`; otherwise ±1.
- `done`, `ok`, `err` are registered. `ok`/`err` hold until the next frame enters LOW1.
- Back-to-back frames: a new falling edge one cycle after `done` is accepted.

## Configuration
- `SINGLE_CLK_RX_GLITCH_FILTER_EN`
  - Defined: a 3-sample majority filter follows the synchronizer. This adds 2 cycles of latency (`done` at the 5th edge). Pulses of 1 cycle are ignored and lengths are unaffected.
  - Undefined: no filter. A 1-cycle glitch is treated as a segment (short error).

## Structure
- Package `single_clk_pkg`:
  - State enum
  - `err` encoding constants (ERR_NONE, ERR_SHORT, ERR_LONG)
  - Default T_LOW1/T_HIGH/T_LOW2 values, shared with the generator
- Sub-module `single_clk_sync`: 2-flop synchronizer plus the optional majority filter, reset to 1.
- The FSM and counters live in the top.

## Test plan
- Nominal 200/100/200 frame, then line idle high → `done` once; `ok`=1, `err`=0; lengths 200/100/200; `busy` back to 0.
- Tolerance edges: LOW1=196, HIGH=104, LOW2=204 → `ok`=1. LOW1=205 → `done` with `err`=2, `len_low1`=205, DRAIN, no second `done`.
- HIGH=50 → frame completes; `ok`=0, `err`=1, `len_high`=50, `len_low2`=200.
- Assert `rst` during HIGH → all outputs 0 next cycle, no `done`. Then a nominal frame → `ok`=1.
- 1-cycle high glitch at LOW1 cycle 100 → with the macro, `ok`=1 and `len_low1`=200. Without it, `ok`=0 and `err`=1.
- Two nominal frames with one idle cycle between them → two `done` pulses, both `ok`=1.

Source files
------------

// File: rtl/single_clk_pkg.sv
// Shared types and defaults for the single_clk frame generator and receiver.
// SYNC_LAT is the sig_in-to-sig_s latency; SINGLE_CLK_RX_GLITCH_FILTER_EN lengthens it.
package single_clk_pkg;
   typedef enum logic [2:0] {IDLE, LOW1, HIGH, LOW2, DRAIN} state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SHORT = 2'd1;
   localparam logic [1:0] ERR_LONG  = 2'd2;

   localparam int DEF_T_LOW1 = 200;
   localparam int DEF_T_HIGH = 100;
   localparam int DEF_T_LOW2 = 200;
   localparam int DEF_TOL    = 4;

`ifdef SINGLE_CLK_RX_GLITCH_FILTER_EN
   localparam int SYNC_LAT = 4;
`else
   localparam int SYNC_LAT = 2;
`endif
endpackage

// File: rtl/single_clk_sync.sv
// Frame-line synchronizer, reset to idle-high; 2 cycles, +2 with SINGLE_CLK_RX_GLITCH_FILTER_EN.
// No backpressure: continuous sampling.
module single_clk_sync (
   input  logic clk_in,
   input  logic rst,
   input  logic sig_in,
   output logic sig_s
);
   logic [1:0] sync;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], sig_in};
   end

`ifdef SINGLE_CLK_RX_GLITCH_FILTER_EN
   logic [1:0] hist;
   logic       filt;

   // registered 3-sample majority: a lone 1-cycle sample never wins
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         hist <= 2'b11;
         filt <= 1'b1;
      end else begin
         hist <= {hist[0], sync[1]};
         filt <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
      end
   end
   assign sig_s = filt;
`else
   assign sig_s = sync[1];
`endif
endmodule

// File: rtl/single_clk_rx.sv
// Low-high-low frame checker: measures each segment, reports ok/err with one done pulse.
// done 3 edges after line returns high (5 with SINGLE_CLK_RX_GLITCH_FILTER_EN); no backpressure.
module single_clk_rx import single_clk_pkg::*; #(
   parameter int T_LOW1 = DEF_T_LOW1,
   parameter int T_HIGH = DEF_T_HIGH,
   parameter int T_LOW2 = DEF_T_LOW2,
   parameter int TOL    = DEF_TOL,
   parameter int CW     = 16
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          sig_in,
   output logic          busy,
   output logic          done,
   output logic          ok,
   output logic [1:0]    err,
   output logic [CW-1:0] len_low1,
   output logic [CW-1:0] len_high,
   output logic [CW-1:0] len_low2
);
   localparam logic [CW-1:0] LOW1_MIN = CW'(T_LOW1 - TOL);
   localparam logic [CW-1:0] LOW1_MAX = CW'(T_LOW1 + TOL + 1);
   localparam logic [CW-1:0] HIGH_MIN = CW'(T_HIGH - TOL);
   localparam logic [CW-1:0] HIGH_MAX = CW'(T_HIGH + TOL + 1);
   localparam logic [CW-1:0] LOW2_MIN = CW'(T_LOW2 - TOL);
   localparam logic [CW-1:0] LOW2_MAX = CW'(T_LOW2 + TOL + 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [2:0]    WARM_LAST = 3'(SYNC_LAT);
   localparam logic [2:0]    ARMED     = 3'(SYNC_LAT + 1);

   state_t        state;
   logic [CW-1:0] cnt, cnt_inc, seg_min, seg_max, seg_len;
   logic          sig_s, seg_lvl, seg_end, seg_long, seg_short, short_flag;
   logic [2:0]    warm;

   single_clk_sync u_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .sig_in (sig_in),
      .sig_s  (sig_s)
   );

   always_comb begin
      seg_min = LOW1_MIN;
      seg_max = LOW1_MAX;
      case (state)
         HIGH:    begin seg_min = HIGH_MIN; seg_max = HIGH_MAX; end
         LOW2:    begin seg_min = LOW2_MIN; seg_max = LOW2_MAX; end
         default: ;
      endcase
   end

   assign cnt_inc   = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
   assign seg_lvl   = (state == HIGH);
   assign seg_end   = (sig_s != seg_lvl);
   assign seg_long  = (cnt_inc >= seg_max) || (cnt == CNT_MAX);
   assign seg_short = (cnt < seg_min);
   assign seg_len   = seg_end ? cnt : cnt_inc;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ok         <= 1'b0;
         err        <= ERR_NONE;
         len_low1   <= '0;
         len_high   <= '0;
         len_low2   <= '0;
         short_flag <= 1'b0;
         warm       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // sig_s is only trustworthy once the synchronizer has refilled after reset
               if (warm < WARM_LAST) begin
                  warm <= warm + 3'd1;
               end else if (warm == WARM_LAST) begin
                  warm <= ARMED;
                  if (!sig_s) state <= DRAIN;
               end else if (!sig_s) begin
                  state      <= LOW1;
                  cnt        <= CW'(1);
                  busy       <= 1'b1;
                  ok         <= 1'b0;
                  err        <= ERR_NONE;
                  short_flag <= 1'b0;
                  len_low1   <= '0;
                  len_high   <= '0;
                  len_low2   <= '0;
               end
            end
            LOW1, HIGH, LOW2: begin
               if (seg_end || seg_long) begin
                  case (state)
                     LOW1:    len_low1 <= seg_len;
                     HIGH:    len_high <= seg_len;
                     default: len_low2 <= seg_len;
                  endcase
               end
               if (seg_end) begin
                  cnt <= CW'(1);
                  if (state == LOW2) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     ok    <= !(short_flag || seg_short);
                     err   <= (short_flag || seg_short) ? ERR_SHORT : ERR_NONE;
                  end else begin
                     short_flag <= short_flag | seg_short;
                     state      <= (state == LOW1) ? HIGH : LOW2;
                  end
               end else if (seg_long) begin
                  cnt   <= cnt_inc;
                  state <= DRAIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  ok    <= 1'b0;
                  err   <= ERR_LONG;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DRAIN: if (sig_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_single_clk_rx.sv
// Directed and random frames against a run-length reference model of the frame rules.
module tb_single_clk_rx;
   localparam int CW  = 16;
   localparam int TOL = 4;
`ifdef SINGLE_CLK_RX_GLITCH_FILTER_EN
   localparam int LAT  = 4;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 2;
   localparam bit FILT = 1'b0;
`endif

   typedef struct {bit lvl; int len; int st;} run_t;
   typedef struct {int edge_i; logic ok; logic [1:0] err; int l1; int h; int l2;} ev_t;

   logic          clk_in = 1'b0;
   logic          rst = 1'b1;
   logic          sig_in = 1'b1;
   logic          busy, done, ok;
   logic [1:0]    err;
   logic [CW-1:0] len_low1, len_high, len_low2;

   int   ecnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tseg [3] = '{200, 100, 200};
   run_t runs[$];
   ev_t  got[$];
   ev_t  exp_q[$];

   single_clk_rx #(.T_LOW1(200), .T_HIGH(100), .T_LOW2(200), .TOL(TOL), .CW(CW)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .sig_in   (sig_in),
      .busy     (busy),
      .done     (done),
      .ok       (ok),
      .err      (err),
      .len_low1 (len_low1),
      .len_high (len_high),
      .len_low2 (len_low2)
   );

   always #50 clk_in = ~clk_in;
   always @(posedge clk_in) ecnt <= ecnt + 1;

   always @(negedge clk_in)
      if (done === 1'b1)
         got.push_back('{ecnt, ok, err, int'(len_low1), int'(len_high), int'(len_low2)});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic add(input bit lvl, input int len);
      runs.push_back('{lvl, len, 0});
   endtask

   task automatic drive();
      for (int i = 0; i < runs.size(); i++) begin
         sig_in = runs[i].lvl;
         runs[i].st = ecnt + 1;
         repeat (runs[i].len) @(posedge clk_in);
         #1;
      end
   endtask

   // Frame rules applied to the run-length view of the line
   task automatic model(input bit start_drained);
      run_t r[$];
      int   mode, seg, lim, k;
      bit   sh;
      int   lens [3];
      ev_t  e;
      exp_q.delete();
      k = 0;
      while (k < runs.size()) begin
         if (FILT && runs[k].len == 1 && k > 0 && k + 1 < runs.size()) begin
            r[r.size()-1].len += 1 + runs[k+1].len;
            k += 2;
         end else begin
            r.push_back(runs[k]);
            k++;
         end
      end
      mode = (start_drained && r[0].lvl == 1'b0) ? 2 : 0;
      seg = 0; sh = 0; lens = '{0, 0, 0};
      for (int i = 0; i < r.size(); i++) begin
         if (mode == 2) begin
            if (r[i].lvl) mode = 0;
            continue;
         end
         if (mode == 0) begin
            if (r[i].lvl) continue;
            mode = 1; seg = 0; sh = 0; lens = '{0, 0, 0};
         end
         lim = tseg[seg] + TOL + 1;
         if (r[i].len >= lim) begin
            lens[seg] = lim;
            e = '{r[i].st + lim - 1 + LAT, 1'b0, 2'd2, lens[0], lens[1], lens[2]};
            exp_q.push_back(e);
            mode = (r[i].lvl && r[i].len > lim) ? 0 : 2;
         end else begin
            lens[seg] = r[i].len;
            if (r[i].len < tseg[seg] - TOL) sh = 1;
            if (seg == 2) begin
               e = '{r[i].st + r[i].len + LAT, !sh, sh ? 2'd1 : 2'd0, lens[0], lens[1], lens[2]};
               exp_q.push_back(e);
               mode = 0;
            end else begin
               seg++;
            end
         end
      end
   endtask

   task automatic episode(input string name, input bit low_at_reset);
      rst = 1'b1;
      sig_in = runs[0].lvl;
      repeat (3) @(posedge clk_in);
      #1;
      got.delete();
      rst = 1'b0;
      drive();
      model(low_at_reset);
      check({name, ".done_count"}, got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
         check($sformatf("%s[%0d].edge", name, k), got[k].edge_i, exp_q[k].edge_i);
         check($sformatf("%s[%0d].ok", name, k), got[k].ok, exp_q[k].ok);
         check($sformatf("%s[%0d].err", name, k), got[k].err, exp_q[k].err);
         check($sformatf("%s[%0d].len_low1", name, k), got[k].l1, exp_q[k].l1);
         check($sformatf("%s[%0d].len_high", name, k), got[k].h, exp_q[k].h);
         check($sformatf("%s[%0d].len_low2", name, k), got[k].l2, exp_q[k].l2);
      end
      check({name, ".busy_end"}, busy, 1'b0);
      if (exp_q.size() > 0) begin
         check({name, ".ok_hold"}, ok, exp_q[exp_q.size()-1].ok);
         check({name, ".err_hold"}, err, exp_q[exp_q.size()-1].err);
         check({name, ".len_low2_hold"}, len_low2, exp_q[exp_q.size()-1].l2);
      end
      runs.delete();
   endtask

   task automatic nominal();
      add(0, 200); add(1, 100); add(0, 200);
   endtask

   initial begin
      #1;
      check("reset.busy", busy, 1'b0);
      check("reset.done", done, 1'b0);
      check("reset.ok", ok, 1'b0);
      check("reset.err", err, 2'd0);
      check("reset.len_low1", len_low1, 16'd0);
      check("reset.len_high", len_high, 16'd0);
      check("reset.len_low2", len_low2, 16'd0);

      add(1, 10); nominal(); add(1, 300);
      episode("nominal", 1'b0);

      add(1, 10); add(0, 196); add(1, 104); add(0, 204); add(1, 300);
      episode("tol_edges", 1'b0);

      add(1, 10); add(0, 210); add(1, 300);
      episode("low1_long", 1'b0);

      add(1, 10); add(0, 200); add(1, 50); add(0, 200); add(1, 300);
      episode("high_short", 1'b0);

      add(1, 10); add(0, 100); add(1, 1); add(0, 99); add(1, 100); add(0, 200); add(1, 300);
      episode("glitch", 1'b0);

      add(1, 10); nominal(); add(1, 1); nominal(); add(1, 300);
      episode("back_to_back", 1'b0);

      add(0, 300); add(1, 20); nominal(); add(1, 300);
      episode("low_at_reset", 1'b1);

      got.delete();
      sig_in = 1'b1; repeat (10) @(posedge clk_in); #1;
      sig_in = 1'b0; repeat (200) @(posedge clk_in); #1;
      sig_in = 1'b1; repeat (50) @(posedge clk_in); #1;
      check("mid_reset.busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_reset.busy", busy, 1'b0);
      check("mid_reset.ok", ok, 1'b0);
      check("mid_reset.err", err, 2'd0);
      check("mid_reset.len_low1", len_low1, 16'd0);
      @(negedge clk_in);
      check("mid_reset.done", done, 1'b0);
      check("mid_reset.no_done", got.size(), 0);
      add(1, 20); nominal(); add(1, 300);
      episode("after_reset", 1'b0);

      add(1, 10);
      for (int f = 0; f < 8; f++) begin
         add(0, $urandom_range(208, 192));
         add(1, $urandom_range(108, 92));
         add(0, $urandom_range(208, 192));
         add(1, $urandom_range(6, 1));
      end
      add(1, 300);
      episode("random", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
